// File: rtl/parking_pass_entry.sv
// Keypad password entry for the car park gate: debounces four digit keys,
// collects two digits and offers them to the gate controller via valid/ack.
module parking_pass_entry #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 50,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  input  logic       key_clr,
  input  logic       sensor_trig,
  input  logic       ack,
  output logic [1:0] password1,
  output logic [1:0] password2,
  output logic       pass_valid,
  output logic       busy,
  output logic [1:0] digit_cnt,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIGIT1,
    S_DIGIT2,
    S_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_PRE  = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [3:0]       r_prev_key;
  logic [CNT_W-1:0] r_stab_cnt;
  logic [CNT_W-1:0] r_zero_cnt;
  logic             r_released;
  logic             r_press;
  logic [1:0]       r_ev_digit;

  logic             w_stable;
  logic [1:0]       w_digit;

  assign w_stable = $onehot(key) && (key == r_prev_key);
  assign w_digit  = {key[3] | key[2], key[3] | key[1]};

  // Press fires as the stable count reaches DEBOUNCE_CYCLES-1, once per release.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_key <= '0;
      r_stab_cnt <= '0;
      r_zero_cnt <= '0;
      r_released <= 1'b0;
      r_press    <= 1'b0;
      r_ev_digit <= '0;
    end else begin
      r_prev_key <= key;
      r_press    <= 1'b0;
      if (w_stable) begin
        if (r_stab_cnt != DB_LAST)
          r_stab_cnt <= r_stab_cnt + ONE;
      end else begin
        r_stab_cnt <= '0;
      end
      if (w_stable && r_stab_cnt == DB_PRE && r_released) begin
        r_press    <= 1'b1;
        r_released <= 1'b0;
        r_ev_digit <= w_digit;
      end
      if (key == 4'b0000) begin
        if (r_zero_cnt == DB_LAST)
          r_released <= 1'b1;
        else
          r_zero_cnt <= r_zero_cnt + ONE;
      end else begin
        r_zero_cnt <= '0;
      end
    end
  end

  state_t           r_state, w_state;
  logic [1:0]       r_p1, w_p1;
  logic [1:0]       r_p2, w_p2;
  logic [1:0]       r_cnt, w_cnt;
  logic [CNT_W-1:0] r_tcnt, w_tcnt;
  logic             r_terr, w_terr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_p1    <= '0;
      r_p2    <= '0;
      r_cnt   <= '0;
      r_tcnt  <= '0;
      r_terr  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_p1    <= w_p1;
      r_p2    <= w_p2;
      r_cnt   <= w_cnt;
      r_tcnt  <= w_tcnt;
      r_terr  <= w_terr;
    end
  end

  always_comb begin
    w_state = r_state;
    w_p1    = r_p1;
    w_p2    = r_p2;
    w_cnt   = r_cnt;
    w_tcnt  = r_tcnt;
    w_terr  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (sensor_trig) begin
          w_state = S_DIGIT1;
          w_tcnt  = '0;
        end
      end
      S_DIGIT1, S_DIGIT2: begin
        if (!sensor_trig) begin
          w_state = S_IDLE;
          w_p1    = '0;
          w_p2    = '0;
          w_cnt   = '0;
          w_tcnt  = '0;
        end else if (key_clr) begin
          w_state = S_DIGIT1;
          w_p1    = '0;
          w_p2    = '0;
          w_cnt   = '0;
          w_tcnt  = '0;
        end else if (r_press) begin
          w_tcnt = '0;
          if (r_state == S_DIGIT1) begin
            w_p1    = r_ev_digit;
            w_cnt   = 2'd1;
            w_state = S_DIGIT2;
          end else begin
            w_p2    = r_ev_digit;
            w_cnt   = 2'd2;
            w_state = S_HOLD;
          end
        end else if (r_tcnt == TO_LAST) begin
          w_state = S_IDLE;
          w_p1    = '0;
          w_p2    = '0;
          w_cnt   = '0;
          w_tcnt  = '0;
          w_terr  = 1'b1;
        end else begin
          w_tcnt = r_tcnt + ONE;
        end
      end
      S_HOLD: begin
        if (ack) begin
          w_state = S_IDLE;
          w_p1    = '0;
          w_p2    = '0;
          w_cnt   = '0;
          w_tcnt  = '0;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign password1   = r_p1;
  assign password2   = r_p2;
  assign digit_cnt   = r_cnt;
  assign timeout_err = r_terr;
  assign pass_valid  = (r_state == S_HOLD);
  assign busy        = (r_state != S_IDLE);

endmodule
